// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   XLEN    : operand/result width (32 only)
//   OP_*    : funct3 encodings of the M-extension operations
//   state_t : controller states
package muldiv_seq_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake bundle for muldiv_seq.
//   master (pipeline) drives StartE, funct3E, SrcAE, SrcBE, FlushE
//   slave  (muldiv)   drives BusyE, DoneE, ResultE
interface muldiv_seq_if #(
   parameter int XLEN = muldiv_seq_pkg::XLEN
);
   logic            StartE;
   logic [2:0]      funct3E;
   logic [XLEN-1:0] SrcAE;
   logic [XLEN-1:0] SrcBE;
   logic            FlushE;
   logic            BusyE;
   logic            DoneE;
   logic [XLEN-1:0] ResultE;

   modport master (
      output StartE, funct3E, SrcAE, SrcBE, FlushE,
      input  BusyE, DoneE, ResultE
   );

   modport slave (
      input  StartE, funct3E, SrcAE, SrcBE, FlushE,
      output BusyE, DoneE, ResultE
   );
endinterface

// File: rtl/muldiv_dp.sv
// Iteration datapath: shift-add multiplier and restoring divider on
// unsigned magnitudes, one step per cycle.
//   clk, reset   : clock, async active-high reset
//   load         : capture a_mag/b_mag and initialise the iteration
//   step         : perform one iteration
//   is_div       : step selects divide (1) or multiply (0)
//   a_mag, b_mag : operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   prod         : 2*XLEN-bit unsigned product
//   quo, rem     : unsigned quotient and remainder
module muldiv_dp #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   a_mag,
   input  logic [XLEN-1:0]   b_mag,
   output logic [2*XLEN-1:0] prod,
   output logic [XLEN-1:0]   quo,
   output logic [XLEN-1:0]   rem
);

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   remr;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     diff;

   always_comb begin
      // multiplier bits sit in acc low half and shift out as the product shifts in
      add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      // restoring trial subtract: partial remainder with next dividend bit
      shifted = {remr, quot[XLEN-1]};
      diff    = shifted - {1'b0, opb};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         opb  <= '0;
         quot <= '0;
         remr <= '0;
      end else if (load) begin
         acc  <= {{XLEN{1'b0}}, a_mag};
         opb  <= b_mag;
         quot <= a_mag;
         remr <= '0;
      end else if (step) begin
         if (is_div) begin
            if (!diff[XLEN]) begin
               remr <= diff[XLEN-1:0];
               quot <= {quot[XLEN-2:0], 1'b1};
            end else begin
               remr <= shifted[XLEN-1:0];
               quot <= {quot[XLEN-2:0], 1'b0};
            end
         end else begin
            acc <= {add_sum, acc[XLEN-1:1]};
         end
      end
   end

   assign prod = acc;
   assign quo  = quot;
   assign rem  = remr;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit for the execute stage.
//   clk, reset : clock, async active-high reset
//   bus        : muldiv_seq_if.slave (StartE/funct3E/SrcAE/SrcBE/FlushE in,
//                BusyE/DoneE/ResultE out)
//
// state | meaning
// IDLE  | waiting for StartE; special cases go straight to DONE
// RUN   | 32 iterations, counter 0..31
// DONE  | DoneE pulse with sign-corrected ResultE, then IDLE
module muldiv_seq #(
   parameter int XLEN = muldiv_seq_pkg::XLEN
) (
   input  logic        clk,
   input  logic        reset,
   muldiv_seq_if.slave bus
);
   import muldiv_seq_pkg::*;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nxt;
   logic [5:0]        cnt;
   logic [2:0]        op_q;
   logic              a_neg_q, b_neg_q, spec_q;
   logic [XLEN-1:0]   spec_val_q, hold_q;

   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, ovf, special, accept;
   logic [XLEN-1:0]   spec_val;
   logic              busy, done, load, step;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo, rem, quo_s, rem_s, done_res;

   always_comb begin
      a_signed = (bus.funct3E == OP_MULH) || (bus.funct3E == OP_MULHSU) ||
                 (bus.funct3E == OP_DIV)  || (bus.funct3E == OP_REM);
      b_signed = (bus.funct3E == OP_MULH) || (bus.funct3E == OP_DIV) ||
                 (bus.funct3E == OP_REM);
      a_neg    = a_signed & bus.SrcAE[XLEN-1];
      b_neg    = b_signed & bus.SrcBE[XLEN-1];
      a_mag    = a_neg ? -bus.SrcAE : bus.SrcAE;
      b_mag    = b_neg ? -bus.SrcBE : bus.SrcBE;
      div_zero = bus.funct3E[2] && (bus.SrcBE == '0);
      ovf      = ((bus.funct3E == OP_DIV) || (bus.funct3E == OP_REM)) &&
                 (bus.SrcAE == MIN_NEG) && (bus.SrcBE == '1);
      special  = div_zero | ovf;
      // funct3E[1] distinguishes REM/REMU from DIV/DIVU
      if (div_zero) spec_val = bus.funct3E[1] ? bus.SrcAE : '1;
      else          spec_val = bus.funct3E[1] ? '0 : MIN_NEG;
      accept   = (state == IDLE) && bus.StartE && !bus.FlushE;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               load      = ~special;
               busy      = ~special;
               state_nxt = special ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == 6'd31) state_nxt = DONE;
         end
         DONE: begin
            done      = ~bus.FlushE;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.FlushE) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         op_q       <= '0;
         a_neg_q    <= 1'b0;
         b_neg_q    <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         hold_q     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q       <= bus.funct3E;
            a_neg_q    <= a_neg;
            b_neg_q    <= b_neg;
            spec_q     <= special;
            spec_val_q <= spec_val;
            cnt        <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
         end
         if (done) hold_q <= done_res;
      end
   end

   muldiv_dp #(.XLEN(XLEN)) u_dp (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .is_div (op_q[2]),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .prod   (prod),
      .quo    (quo),
      .rem    (rem)
   );

   always_comb begin
      prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
      quo_s  = (a_neg_q ^ b_neg_q) ? -quo  : quo;
      rem_s  = a_neg_q ? -rem : rem;
      case (op_q)
         OP_MUL:                       done_res = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: done_res = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              done_res = quo_s;
         default:                      done_res = rem_s;
      endcase
      if (spec_q) done_res = spec_val_q;
   end

   assign bus.BusyE   = busy;
   assign bus.DoneE   = done;
   assign bus.ResultE = done ? done_res : hold_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_seq_if bus ();
   muldiv_seq dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // Architectural reference using wide integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f3)
         OP_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
         OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = 64'(sa / sb); return p[31:0];
         end
         OP_DIVU: begin
            if (b == 0) return 32'hFFFFFFFF;
            p = 64'(ua / ub); return p[31:0];
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            p = 64'(sa % sb); return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = 64'(ua % ub); return p[31:0];
         end
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == OP_DIV || f3 == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issues one op; lat = cycles from the start cycle to the DoneE cycle,
   // busy_n = cycles with BusyE high from the start cycle to the DoneE cycle.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, output logic [31:0] res, output int lat, output int busy_n);
      @(negedge clk);
      bus.StartE = 1'b1; bus.funct3E = f3; bus.SrcAE = a; bus.SrcBE = b; bus.FlushE = 1'b0;
      #1;
      busy_n = int'(bus.BusyE);
      lat    = -1;
      res    = 32'h0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (noise && $urandom_range(0, 1) == 1) begin
            bus.StartE  = 1'b1;
            bus.funct3E = 3'($urandom_range(0, 7));
            bus.SrcAE   = $urandom;
            bus.SrcBE   = $urandom;
         end else begin
            bus.StartE = 1'b0;
         end
         #1;
         busy_n += int'(bus.BusyE);
         if (bus.DoneE) begin
            res = bus.ResultE;
            lat = c;
            break;
         end
      end
      bus.StartE = 1'b0;
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL timeout: got=no DoneE expected=DoneE within 100 cycles");
      end
   endtask

   task automatic watch_no_done(input string name, input int cycles, input logic [31:0] exp_res);
      int dones;
      logic [31:0] last;
      dones = 0;
      last  = exp_res;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         #1;
         dones += int'(bus.DoneE);
         if (bus.ResultE !== exp_res) last = bus.ResultE;
      end
      check({name, " no DoneE"}, 32'(dones), 32'd0);
      check({name, " ResultE held"}, last, exp_res);
   endtask

   initial begin
      logic [31:0] r, prev;
      int l, bn;

      vecs.push_back('{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
      vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
      vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
      vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
      vecs.push_back('{OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 33});
      vecs.push_back('{OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 33});
      vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
      vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
      vecs.push_back('{OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33});
      vecs.push_back('{OP_REM,    32'd100,      32'hFFFFFFF9, 32'h00000002, 33});
      vecs.push_back('{OP_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33});
      vecs.push_back('{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
      vecs.push_back('{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
      vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{OP_REMU,   32'd5,        32'd0,        32'h00000005, 1});
      vecs.push_back('{OP_DIV,    32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{OP_REM,    32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1});
      vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
      vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

      bus.StartE = 1'b0; bus.funct3E = 3'b0; bus.SrcAE = '0; bus.SrcBE = '0; bus.FlushE = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset BusyE", 32'(bus.BusyE), 32'd0);
      check("reset DoneE", 32'(bus.DoneE), 32'd0);
      check("reset ResultE", bus.ResultE, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, r, l, bn);
         check($sformatf("vec%0d result", i), r, vecs[i].res);
         check($sformatf("vec%0d latency", i), 32'(l), 32'(vecs[i].lat));
         check($sformatf("vec%0d busy cycles", i), 32'(bn), (vecs[i].lat == 33) ? 32'd33 : 32'd0);
         @(negedge clk);
         #1;
         check($sformatf("vec%0d DoneE pulse ends", i), 32'(bus.DoneE), 32'd0);
         check($sformatf("vec%0d ResultE hold", i), bus.ResultE, vecs[i].res);
      end

      // flush in RUN at counter 10
      run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, r, l, bn);
      check("pre-flush result", r, 32'd14);
      prev = 32'd14;
      @(negedge clk);
      bus.StartE = 1'b1; bus.funct3E = OP_MUL; bus.SrcAE = 32'd3; bus.SrcBE = 32'd5;
      @(negedge clk);
      bus.StartE = 1'b0;
      repeat (10) @(negedge clk);
      bus.FlushE = 1'b1;
      @(negedge clk);
      bus.FlushE = 1'b0;
      #1;
      check("flush BusyE", 32'(bus.BusyE), 32'd0);
      check("flush DoneE", 32'(bus.DoneE), 32'd0);
      check("flush ResultE", bus.ResultE, prev);
      watch_no_done("after flush", 40, prev);
      run_op(OP_MUL, 32'd3, 32'd5, 1'b0, r, l, bn);
      check("restart result", r, 32'd15);
      check("restart latency", 32'(l), 32'd33);

      // same sequence with reset
      @(negedge clk);
      bus.StartE = 1'b1; bus.funct3E = OP_MUL; bus.SrcAE = 32'd9; bus.SrcBE = 32'd9;
      @(negedge clk);
      bus.StartE = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset-run BusyE", 32'(bus.BusyE), 32'd0);
      check("reset-run DoneE", 32'(bus.DoneE), 32'd0);
      check("reset-run ResultE", bus.ResultE, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      watch_no_done("after reset", 40, 32'h0);
      run_op(OP_MUL, 32'd9, 32'd9, 1'b0, r, l, bn);
      check("post-reset result", r, 32'd81);

      // FlushE wins over StartE in IDLE, both for normal and special ops
      @(negedge clk);
      bus.StartE = 1'b1; bus.FlushE = 1'b1; bus.funct3E = OP_MUL; bus.SrcAE = 32'd2; bus.SrcBE = 32'd2;
      #1;
      check("flush+start BusyE", 32'(bus.BusyE), 32'd0);
      @(negedge clk);
      bus.funct3E = OP_DIVU; bus.SrcAE = 32'd5; bus.SrcBE = 32'd0;
      @(negedge clk);
      bus.StartE = 1'b0; bus.FlushE = 1'b0;
      watch_no_done("flush+start", 40, 32'd81);

      // randomized ops with StartE noise while busy
      for (int i = 0; i < 60; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         run_op(f3, a, b, 1'b1, r, l, bn);
         check($sformatf("rand%0d f3=%0d a=%h b=%h result", i, f3, a, b), r, model(f3, a, b));
         check($sformatf("rand%0d latency", i), 32'(l), 32'(model_lat(f3, a, b)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
